// File: rtl/db_fe_ctrl_pkg.sv
// Shared constants for the daughterboard front-end control responder:
// settings/readback offsets and ATR state encoding.
package db_fe_ctrl_pkg;

  localparam int SR_NUM = 8;
  localparam int RB_NUM = 8;

  localparam logic [7:0] SR_ATR_IDLE    = 8'd0;
  localparam logic [7:0] SR_ATR_RX      = 8'd1;
  localparam logic [7:0] SR_ATR_TX      = 8'd2;
  localparam logic [7:0] SR_ATR_FDX     = 8'd3;
  localparam logic [7:0] SR_DDR         = 8'd4;
  localparam logic [7:0] SR_ATR_DISABLE = 8'd5;
  localparam logic [7:0] SR_MANUAL      = 8'd6;
  localparam logic [7:0] SR_ATR_DELAY   = 8'd7;

  localparam logic [7:0] RB_ATR  = 8'd0;
  localparam logic [7:0] RB_GPIO = 8'd1;
  localparam logic [7:0] RB_OUT  = 8'd2;

  // Encoding is {tx_running, rx_running}.
  typedef enum logic [1:0] {
    ATR_IDLE = 2'b00,
    ATR_RX   = 2'b01,
    ATR_TX   = 2'b10,
    ATR_FDX  = 2'b11
  } atr_state_t;

  typedef enum logic {
    PH_STABLE = 1'b0,
    PH_COUNT  = 1'b1
  } atr_phase_t;

  function automatic logic in_window(input logic [7:0] addr, input logic [7:0] base,
                                     input int num);
    return (addr >= base) && ((addr - base) < 8'(num));
  endfunction

endpackage

// File: rtl/db_fe_ctrl_responder_if.sv
// Settings-bus write port and readback port of the front-end control responder.
interface db_fe_ctrl_responder_if;
  import db_fe_ctrl_pkg::*;

  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;

  // Readback: rb_data is valid for rb_addr whenever rb_stb is high. Any change
  // of rb_addr drops rb_stb for two cycles; it stays high while rb_addr holds.
  logic [7:0]  rb_addr;
  logic        rb_stb;
  logic [63:0] rb_data;

  atr_phase_t  atr_phase;

  modport master (
    output set_stb, set_addr, set_data, rb_addr,
    input  rb_stb, rb_data, atr_phase
  );

  modport slave (
    input  set_stb, set_addr, set_data, rb_addr,
    output rb_stb, rb_data, atr_phase
  );

endinterface

// File: rtl/db_fe_atr_fsm.sv
// ATR sequencer: registers radio activity as a target state and applies it
// after ATR_DELAY cycles, restarting or cancelling when the target moves.
module db_fe_atr_fsm
  import db_fe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_running,
  input  logic        tx_running,
  input  logic [15:0] atr_delay,
  output atr_state_t  applied,
  output atr_state_t  applied_next,
  output logic [15:0] counter,
  output atr_phase_t  phase
);

  atr_state_t  target;
  atr_state_t  pending;
  logic        load;
  logic [15:0] cnt_next;

  // The transition fires on the edge where the loaded/decremented count is 0,
  // so a zero delay applies on the same edge as the load.
  always_comb begin
    applied_next = applied;
    load         = 1'b0;
    cnt_next     = counter;
    if (target != applied) begin
      load     = (phase == PH_STABLE) || (target != pending);
      cnt_next = load ? atr_delay : counter - 16'd1;
      if (cnt_next == 16'd0) applied_next = target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target  <= ATR_IDLE;
      applied <= ATR_IDLE;
      pending <= ATR_IDLE;
      counter <= '0;
      phase   <= PH_STABLE;
    end else begin
      target  <= atr_state_t'({tx_running, rx_running});
      applied <= applied_next;
      if ((target != applied) && (cnt_next != 16'd0)) begin
        counter <= cnt_next;
        pending <= target;
        phase   <= PH_COUNT;
      end else begin
        counter <= '0;
        phase   <= PH_STABLE;
      end
    end
  end

endmodule

// File: rtl/db_fe_ctrl_responder.sv
// Front-end control responder: ATR-driven GPIO with settings-bus registers and
// readback. Define DB_FE_GPIO_READBACK_EN to synchronize and read back gpio_in.
module db_fe_ctrl_responder
  import db_fe_ctrl_pkg::*;
#(
  parameter logic [7:0] SR_BASE    = 8'd160,
  parameter logic [7:0] RB_BASE    = 8'd16,
  parameter int         GPIO_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  db_fe_ctrl_responder_if.slave bus,
  input  logic                  rx_running,
  input  logic                  tx_running,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_ddr
);

  logic [GPIO_WIDTH-1:0] atr    [4];
  logic [GPIO_WIDTH-1:0] atr_nx [4];
  logic [GPIO_WIDTH-1:0] ddr, ddr_nx, dis, dis_nx, man, man_nx;
  logic [15:0]           dly, dly_nx;
  logic [7:0]            set_off, rb_off, rb_addr_q;
  logic                  rb_changed, rb_valid1;
  logic [63:0]           rb_val;
  logic [GPIO_WIDTH-1:0] gpio_sync;
  atr_state_t            applied, applied_next;
  logic [15:0]           counter;

  db_fe_atr_fsm u_atr_fsm (
    .clk          (clk),
    .reset        (reset),
    .rx_running   (rx_running),
    .tx_running   (tx_running),
    .atr_delay    (dly),
    .applied      (applied),
    .applied_next (applied_next),
    .counter      (counter),
    .phase        (bus.atr_phase)
  );

  assign set_off = bus.set_addr - SR_BASE;

  always_comb begin
    atr_nx = atr;
    ddr_nx = ddr;
    dis_nx = dis;
    man_nx = man;
    dly_nx = dly;
    if (bus.set_stb && in_window(bus.set_addr, SR_BASE, SR_NUM)) begin
      case (set_off)
        SR_ATR_IDLE, SR_ATR_RX, SR_ATR_TX, SR_ATR_FDX:
          atr_nx[set_off[1:0]] = bus.set_data[GPIO_WIDTH-1:0];
        SR_DDR:         ddr_nx = bus.set_data[GPIO_WIDTH-1:0];
        SR_ATR_DISABLE: dis_nx = bus.set_data[GPIO_WIDTH-1:0];
        SR_MANUAL:      man_nx = bus.set_data[GPIO_WIDTH-1:0];
        SR_ATR_DELAY:   dly_nx = bus.set_data[15:0];
        default: ;
      endcase
    end
  end

  // Outputs are built from next-state values so a write to the applied
  // state's ATR register lands on gpio_out together with the register itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      atr      <= '{default: '0};
      ddr      <= '0;
      dis      <= '0;
      man      <= '0;
      dly      <= '0;
      gpio_out <= '0;
      gpio_ddr <= '0;
    end else begin
      atr      <= atr_nx;
      ddr      <= ddr_nx;
      dis      <= dis_nx;
      man      <= man_nx;
      dly      <= dly_nx;
      gpio_out <= (atr_nx[applied_next] & ~dis_nx) | (man_nx & dis_nx);
      gpio_ddr <= ddr_nx;
    end
  end

`ifdef DB_FE_GPIO_READBACK_EN
  logic [GPIO_WIDTH-1:0] gpio_meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_meta <= '0;
      gpio_sync <= '0;
    end else begin
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
    end
  end
`else
  logic unused_gpio_in;

  assign unused_gpio_in = ^gpio_in;
  assign gpio_sync      = '0;
`endif

  assign rb_off     = bus.rb_addr - RB_BASE;
  assign rb_changed = (bus.rb_addr != rb_addr_q);

  always_comb begin
    rb_val = '0;
    if (in_window(bus.rb_addr, RB_BASE, RB_NUM)) begin
      case (rb_off)
        RB_ATR:  rb_val = {30'b0, applied, 16'b0, counter};
        RB_GPIO: rb_val = {32'b0, 32'(gpio_sync)};
        RB_OUT:  rb_val = {32'(gpio_ddr), 32'(gpio_out)};
        default: ;
      endcase
    end
  end

  // rb_addr_q follows the bus during reset so a static address is not seen
  // as a change when reset releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      rb_addr_q   <= bus.rb_addr;
      rb_valid1   <= 1'b0;
      bus.rb_stb  <= 1'b0;
      bus.rb_data <= '0;
    end else begin
      rb_addr_q  <= bus.rb_addr;
      rb_valid1  <= !rb_changed;
      bus.rb_stb <= rb_valid1 && !rb_changed;
      if (!rb_changed) bus.rb_data <= rb_val;
    end
  end

endmodule

// File: tb/tb_db_fe_ctrl_responder.sv
// Self-checking bench for db_fe_ctrl_responder: directed ATR/readback scenarios
// plus randomized traffic checked against a time-based behavioural model.
module tb_db_fe_ctrl_responder;
  import db_fe_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        rx_running;
  logic        tx_running;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_ddr;

  db_fe_ctrl_responder_if bus ();

  db_fe_ctrl_responder dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .rx_running (rx_running),
    .tx_running (tx_running),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .gpio_ddr   (gpio_ddr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Model state: time-stamped rather than counter-driven.
  int          cyc = 0;
  int          t_reg, deadline, e_c;
  bit          pend;
  logic [1:0]  tgt_m, app_m;
  logic [31:0] regs_m [8];
  logic [31:0] gs1_m, gs2_m;
  logic [63:0] rb_data_m;
  logic        rb_stb_m;
  logic [7:0]  rb_prev;

  function automatic logic [31:0] out_model();
    return (regs_m[app_m] & ~regs_m[5]) | (regs_m[6] & regs_m[5]);
  endfunction

  function automatic logic [15:0] cnt_model();
    return pend ? 16'(deadline - cyc) : 16'h0;
  endfunction

  function automatic logic [63:0] rb_model(input logic [7:0] a);
    logic [63:0] v;
    v = '0;
    if (a == 8'd16) v = {30'b0, app_m, 16'b0, cnt_model()};
`ifdef DB_FE_GPIO_READBACK_EN
    if (a == 8'd17) v = {32'b0, gs2_m};
`endif
    if (a == 8'd18) v = {regs_m[4], out_model()};
    return v;
  endfunction

  task automatic model_edge();
    logic [63:0] rb_new;
    logic [1:0]  new_tgt;
    logic [7:0]  so;
    rb_new = rb_model(bus.rb_addr);
    cyc++;
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_m[i] = '0;
      tgt_m = 2'b00; app_m = 2'b00; pend = 0; t_reg = cyc; deadline = 0;
      gs1_m = '0; gs2_m = '0; rb_data_m = '0; rb_stb_m = 1'b0;
      rb_prev = bus.rb_addr; e_c = cyc;
    end else begin
      if (bus.rb_addr != rb_prev) e_c = cyc;
      else rb_data_m = rb_new;
      rb_prev  = bus.rb_addr;
      rb_stb_m = (cyc - e_c) >= 2;
      if (tgt_m == app_m) pend = 0;
      else if (t_reg == cyc - 1) begin
        pend     = 1;
        deadline = cyc + int'(regs_m[7][15:0]);
      end
      if (pend && deadline == cyc) begin
        app_m = tgt_m;
        pend  = 0;
      end
      new_tgt = {tx_running, rx_running};
      if (new_tgt != tgt_m) begin
        tgt_m = new_tgt;
        t_reg = cyc;
      end
      so = bus.set_addr - 8'd160;
      if (bus.set_stb && bus.set_addr >= 8'd160 && so < 8'd8)
        regs_m[so[2:0]] = (so == 8'd7) ? {16'h0, bus.set_data[15:0]} : bus.set_data;
      gs2_m = gs1_m;
      gs1_m = gpio_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    bus.set_stb  = 1'b1;
    bus.set_addr = 8'(160 + off);
    bus.set_data = d;
    tick();
    bus.set_stb  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (gpio_out !== 32'h0) begin failures++; $display("FAIL reset_gpio_out got=%h exp=0", gpio_out); end
    checks++;
    if (gpio_ddr !== 32'h0) begin failures++; $display("FAIL reset_gpio_ddr got=%h exp=0", gpio_ddr); end
    checks++;
    if (bus.rb_stb !== 1'b0 || bus.rb_data !== 64'h0) begin
      failures++; $display("FAIL reset_rb got stb=%b data=%h exp stb=0 data=0", bus.rb_stb, bus.rb_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.rb_stb !== 1'b0) begin failures++; $display("FAIL reset_rb_stb_1st got=%b exp=0", bus.rb_stb); end
    tick();
    checks++;
    if (bus.rb_stb !== 1'b1) begin failures++; $display("FAIL reset_rb_stb_2nd got=%b exp=1", bus.rb_stb); end
  endtask

  task automatic test_atr_nodelay();
    wr(1, 32'h0000_00F0);
    wr(7, 32'h0);
    rx_running = 1'b1;
    tick();
    checks++;
    if (gpio_out !== 32'h0) begin failures++; $display("FAIL nodelay_first got=%h exp=0", gpio_out); end
    tick();
    checks++;
    if (gpio_out !== 32'h0000_00F0) begin failures++; $display("FAIL nodelay_second got=%h exp=000000f0", gpio_out); end
  endtask

  task automatic test_atr_delay();
    logic [31:0] exp_q[$];
    logic [31:0] e;
    rx_running = 1'b0;
    repeat (3) tick();
    wr(2, 32'h0000_0F00);
    wr(7, 32'd10);
    for (int i = 0; i < 11; i++) exp_q.push_back(32'h0);
    exp_q.push_back(32'h0000_0F00);
    tx_running = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (gpio_out !== e) begin failures++; $display("FAIL delay_hold step=%0d got=%h exp=%h", i, gpio_out, e); end
      if (i == 1) begin
        checks++;
        if (bus.atr_phase !== PH_COUNT) begin
          failures++; $display("FAIL delay_phase got=%0d exp=%0d", bus.atr_phase, PH_COUNT);
        end
      end
    end
  endtask

  task automatic test_atr_cancel();
    wr(0, 32'h0000_0011);
    tx_running = 1'b0;
    repeat (13) tick();
    checks++;
    if (gpio_out !== 32'h11) begin failures++; $display("FAIL cancel_settle got=%h exp=00000011", gpio_out); end
    rx_running = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) rx_running = 1'b0;
      tick();
      checks++;
      if (gpio_out !== 32'h11) begin failures++; $display("FAIL cancel_hold step=%0d got=%h exp=00000011", i, gpio_out); end
    end
  endtask

  task automatic test_manual();
    wr(0, 32'hFFFF_0000);
    wr(5, 32'h0000_00FF);
    wr(6, 32'h0000_005A);
    tick();
    checks++;
    if (gpio_out !== 32'hFFFF_005A) begin failures++; $display("FAIL manual got=%h exp=ffff005a", gpio_out); end
  endtask

  task automatic test_readback();
    wr(4, 32'h3);
    bus.rb_addr = 8'd16;
    repeat (3) tick();
    bus.rb_addr = 8'd18;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.rb_stb !== 1'b0) begin failures++; $display("FAIL rb_switch_low step=%0d got=%b exp=0", i, bus.rb_stb); end
    end
    tick();
    checks++;
    if (bus.rb_stb !== 1'b1 || bus.rb_data !== 64'h0000_0003_FFFF_005A) begin
      failures++; $display("FAIL rb_switch_data got stb=%b data=%h exp stb=1 data=00000003ffff005a", bus.rb_stb, bus.rb_data);
    end
    checks++;
    if (gpio_ddr !== 32'h3) begin failures++; $display("FAIL ddr got=%h exp=00000003", gpio_ddr); end
    bus.rb_addr = 8'd200;
    repeat (3) tick();
    checks++;
    if (bus.rb_stb !== 1'b1 || bus.rb_data !== 64'h0) begin
      failures++; $display("FAIL rb_out_of_range got stb=%b data=%h exp stb=1 data=0", bus.rb_stb, bus.rb_data);
    end
  endtask

  task automatic test_gpio_readback();
    logic [63:0] e;
`ifdef DB_FE_GPIO_READBACK_EN
    e = 64'hA5;
`else
    e = 64'h0;
`endif
    gpio_in     = 32'hA5;
    bus.rb_addr = 8'd17;
    repeat (3) tick();
    checks++;
    if (bus.rb_stb !== 1'b1 || bus.rb_data !== e) begin
      failures++; $display("FAIL gpio_readback got stb=%b data=%h exp stb=1 data=%h", bus.rb_stb, bus.rb_data, e);
    end
  endtask

  task automatic test_random();
    logic [7:0] rb_pool [5];
    rb_pool = '{8'd16, 8'd17, 8'd18, 8'd19, 8'd200};
    wr(7, 32'd3);
    for (int i = 0; i < 600; i++) begin
      bus.set_stb = ($urandom_range(0, 3) == 0);
      bus.set_addr = 8'(160 + $urandom_range(0, 9));
      bus.set_data = (bus.set_addr == 8'd167) ? 32'($urandom_range(0, 6)) : $urandom;
      if ($urandom_range(0, 5) == 0) rx_running = ~rx_running;
      if ($urandom_range(0, 5) == 0) tx_running = ~tx_running;
      if ($urandom_range(0, 9) == 0) bus.rb_addr = rb_pool[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) gpio_in = $urandom;
      tick();
      checks++;
      if (gpio_out !== out_model()) begin failures++; $display("FAIL rand_gpio_out i=%0d got=%h exp=%h", i, gpio_out, out_model()); end
      checks++;
      if (gpio_ddr !== regs_m[4]) begin failures++; $display("FAIL rand_gpio_ddr i=%0d got=%h exp=%h", i, gpio_ddr, regs_m[4]); end
      checks++;
      if (bus.rb_stb !== rb_stb_m) begin failures++; $display("FAIL rand_rb_stb i=%0d got=%b exp=%b", i, bus.rb_stb, rb_stb_m); end
      checks++;
      if (bus.rb_data !== rb_data_m) begin failures++; $display("FAIL rand_rb_data i=%0d got=%h exp=%h", i, bus.rb_data, rb_data_m); end
    end
    bus.set_stb = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    rx_running   = 1'b0;
    tx_running   = 1'b0;
    gpio_in      = '0;
    bus.set_stb  = 1'b0;
    bus.set_addr = '0;
    bus.set_data = '0;
    bus.rb_addr  = 8'd16;
    @(negedge clk);
    test_reset();
    test_atr_nodelay();
    test_atr_delay();
    test_atr_cancel();
    test_manual();
    test_readback();
    test_gpio_readback();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/db_fe_ctrl_responder.md
DB_FE_CTRL_RESPONDER -- requirements
Module: db_fe_ctrl_responder

Interface
REQ-001 SHALL have parameter SR_BASE, default 8'd160, first settings address owned (register offset 0).
REQ-002 SHALL have parameter RB_BASE, default 8'd16, first readback address owned.
REQ-003 SHALL have parameter GPIO_WIDTH, default 32, width of every GPIO/ATR vector (1..32).
REQ-004 SHALL have ports: clk input 1, the single clock; reset input 1, synchronous active-high.
REQ-005 SHALL have ports: set_stb input 1, set_addr input 8, set_data input 32: timed settings-bus write.
REQ-006 SHALL have ports: rb_addr input 8; rb_stb output 1, readback data valid; rb_data output 64, readback value.
REQ-007 SHALL have ports: rx_running input 1, tx_running input 1: radio activity flags.
REQ-008 SHALL have ports: gpio_in input GPIO_WIDTH, asynchronous pins; gpio_out output GPIO_WIDTH; gpio_ddr output GPIO_WIDTH.

Function
REQ-009 SHALL write register at offset set_addr-SR_BASE on a set_stb cycle; offsets 0 ATR_IDLE, 1 ATR_RX, 2 ATR_TX, 3 ATR_FDX, 4 DDR, 5 ATR_DISABLE, 6 MANUAL, 7 ATR_DELAY[15:0]; other addresses ignored; update visible the next cycle.
REQ-010 SHALL register activity as target state IDLE(00), RX(01), TX(10), FDX(11) = {tx_running, rx_running}, one cycle latency.
REQ-011 SHALL keep an applied state; when target differs from applied, load delay counter with ATR_DELAY and apply target when counter reaches 0, decrementing once per cycle.
REQ-012 SHALL, with ATR_DELAY=0, apply a new target the cycle after it is registered (two cycles from input change to gpio_out change).
REQ-013 SHALL, if target changes again while counting, reload counter with ATR_DELAY for the newest target; if target returns to applied state, cancel counting with no output change.
REQ-014 SHALL drive gpio_out = (ATR value of applied state & ~ATR_DISABLE) | (MANUAL & ATR_DISABLE), registered; gpio_ddr = DDR, registered.
REQ-015 SHALL apply a write to the ATR register of the currently applied state to gpio_out without waiting for the delay.
REQ-016 SHALL decode readback offsets: 0 {30'b0, applied[1:0], 16'b0, counter[15:0]}; 1 {32'b0, synchronized gpio_in zero-extended}; 2 {DDR, gpio_out} zero-extended; other in-range offsets and out-of-range addresses return 0.
REQ-017 SHALL deassert rb_stb the cycle rb_addr differs from its previous-cycle value and the following cycle, update rb_data on that following cycle, and reassert rb_stb on the second cycle after the change.
REQ-018 SHALL hold rb_stb high continuously while rb_addr is stable, including out-of-range addresses, so the upstream readback holdoff never stalls.
REQ-019 SHALL refresh rb_data every cycle while rb_stb is high so live values (counter, gpio) are current.
REQ-020 SHALL prioritize a same-cycle settings write over ATR counter logic, the new ATR_DELAY value taking effect only at the next counter load.

Reset
REQ-021 SHALL reset all registers, counter, applied and target state to 0 (IDLE), gpio_out 0, gpio_ddr 0, rb_data 0, rb_stb 0.
REQ-022 SHALL assert rb_stb the second cycle after reset deasserts; reset mid-count abandons the pending transition.

Configuration
REQ-023 SHALL, with DB_FE_GPIO_READBACK_EN defined, double-flop gpio_in into the clk domain and return it at readback offset 1.
REQ-024 SHALL, without DB_FE_GPIO_READBACK_EN, omit the synchronizer and return 0 at readback offset 1.

Structure
REQ-025 SHALL place register offsets, readback offsets and ATR state encoding in shared package db_fe_ctrl_pkg.
REQ-026 SHALL implement target/applied/delay counter logic in sub-module db_fe_atr_fsm.

Verification
REQ-027 SHALL cover: ATR_RX=0x0000_00F0, ATR_DELAY=0, rx_running 0->1 -> gpio_out=0x0000_00F0 two cycles later.
REQ-028 SHALL cover: ATR_DELAY=10, tx_running rises -> gpio_out holds ATR_IDLE for 11 cycles after target registers, then ATR_TX.
REQ-029 SHALL cover: ATR_DELAY=10, rx_running pulses high 4 cycles -> counting cancelled, gpio_out never leaves ATR_IDLE.
REQ-030 SHALL cover: ATR_DISABLE=0xFF, MANUAL=0x5A, ATR_IDLE=0xFFFF_0000 -> gpio_out=0xFFFF_005A.
REQ-031 SHALL cover: rb_addr switches 8'd16->8'd18 with DDR=0x3 -> rb_stb low two cycles, then rb_data={32'h3, gpio_out} with rb_stb high.
REQ-032 SHALL cover: gpio_in=0xA5 with DB_FE_GPIO_READBACK_EN, rb_addr=8'd17 -> rb_data=64'hA5 within 3 cycles; without macro -> 0.
